// File: rtl/clarvi_regfile_sequencer_pkg.sv
// rtl/clarvi_regfile_sequencer_pkg.sv - shared op and state types for the 64-bit register access sequencer
package clarvi_regfile_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_READ_WRITE = 2'b10,
    OP_NOP        = 2'b11
  } regseq_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_RESP  = 3'd5
  } regseq_state_t;

endpackage

// File: rtl/clarvi_regfile_sequencer_if.sv
// rtl/clarvi_regfile_sequencer_if.sv - request/response handshake between wide-op issue logic and the sequencer
interface clarvi_regfile_sequencer_if
  import clarvi_regfile_sequencer_pkg::*;
#(
  parameter int HALF_W = 32,
  parameter int ADDR_W = 5
);

  logic                  req_valid;
  logic                  req_ready;
  regseq_op_t            req_op;
  logic [ADDR_W-1:0]     req_rs1;
  logic [ADDR_W-1:0]     req_rs2;
  logic [ADDR_W-1:0]     req_rd;
  logic [2*HALF_W-1:0]   req_wdata;
  logic                  req_rs2_low;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2*HALF_W-1:0]   resp_rdata1;
  logic [2*HALF_W-1:0]   resp_rdata2;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, req_rs2_low, resp_ready,
    input  req_ready, resp_valid, resp_rdata1, resp_rdata2, busy
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, req_rs2_low, resp_ready,
    output req_ready, resp_valid, resp_rdata1, resp_rdata2, busy
  );

endinterface

// File: rtl/clarvi_regfile_sequencer.sv
// rtl/clarvi_regfile_sequencer.sv - splits 64-bit register reads/writes into two half accesses on a 2x32 register file
module clarvi_regfile_sequencer
  import clarvi_regfile_sequencer_pkg::*;
#(
  parameter int HALF_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit SKIP_ZERO_WR = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  clarvi_regfile_sequencer_if.slave bus,
  output logic                 rf_fetch_part,
  output logic                 rf_rs2_part_override,
  output logic [ADDR_W-1:0]    rf_fetch_register_1,
  output logic [ADDR_W-1:0]    rf_fetch_register_2,
  output logic                 rf_write_part,
  output logic [ADDR_W-1:0]    rf_write_register,
  output logic [HALF_W-1:0]    rf_data_in,
  output logic                 rf_write_enable,
  input  logic [HALF_W-1:0]    rf_data_out_1,
  input  logic [HALF_W-1:0]    rf_data_out_2
);

  regseq_state_t       state;
  regseq_op_t          op_q;
  logic [ADDR_W-1:0]   rs1_q;
  logic [ADDR_W-1:0]   rs2_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [2*HALF_W-1:0] wdata_q;
  logic                rs2_low_q;
  logic [2*HALF_W-1:0] rdata1_q;
  logic [2*HALF_W-1:0] rdata2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wdata_q   <= '0;
      rs2_low_q <= 1'b0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            rs1_q     <= bus.req_rs1;
            rs2_q     <= bus.req_rs2;
            rd_q      <= bus.req_rd;
            wdata_q   <= bus.req_wdata;
            rs2_low_q <= bus.req_rs2_low;
            // Writes and NOPs report zero rather than stale data from an earlier read.
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            case (bus.req_op)
              OP_READ, OP_READ_WRITE: state <= S_RD_LO;
              OP_WRITE:               state <= S_WR_LO;
              default:                state <= S_RESP;
            endcase
          end
        end
        S_RD_LO: begin
          rdata1_q[HALF_W-1:0] <= rf_data_out_1;
          rdata2_q[HALF_W-1:0] <= rf_data_out_2;
          state                <= S_RD_HI;
        end
        S_RD_HI: begin
          rdata1_q[2*HALF_W-1:HALF_W] <= rf_data_out_1;
          rdata2_q[2*HALF_W-1:HALF_W] <= rs2_low_q ? '0 : rf_data_out_2;
          state <= (op_q == OP_READ_WRITE) ? S_WR_LO : S_RESP;
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: state <= S_RESP;
        S_RESP:  if (bus.resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic rd_phase;
  logic wr_phase;
  assign rd_phase = (state == S_RD_LO) || (state == S_RD_HI);
  assign wr_phase = (state == S_WR_LO) || (state == S_WR_HI);

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.resp_valid  = (state == S_RESP);
  assign bus.busy        = (state != S_IDLE);
  assign bus.resp_rdata1 = rdata1_q;
  assign bus.resp_rdata2 = rdata2_q;

  // Register file controls come only from state and latched fields so they are quiet in IDLE.
  assign rf_fetch_part        = (state == S_RD_HI);
  assign rf_rs2_part_override = rd_phase && rs2_low_q;
  assign rf_fetch_register_1  = rd_phase ? rs1_q : '0;
  assign rf_fetch_register_2  = rd_phase ? rs2_q : '0;
  assign rf_write_part        = (state == S_WR_HI);
  assign rf_write_register    = wr_phase ? rd_q : '0;
  assign rf_data_in           = (state == S_WR_LO) ? wdata_q[HALF_W-1:0] :
                                (state == S_WR_HI) ? wdata_q[2*HALF_W-1:HALF_W] : '0;
  assign rf_write_enable      = wr_phase && !(SKIP_ZERO_WR && (rd_q == '0));

endmodule
